// File: rtl/cpu_cache_pkg.sv
// Shared types and geometry for the cache miss-fill path.
package cpu_cache_pkg;

    // Byte offset bits within a 16-byte block.
    localparam int BLOCK_OFFSET_W  = 4;
    // Word index bits within a block (eight 16-bit words).
    localparam int WORD_IDX_W      = 3;
    localparam int WORDS_PER_BLOCK = 8;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/cache_fill_cnt.sv
// Small up-counter with enable and synchronous clear; optionally
// saturates at MAX_VAL instead of wrapping.
module cache_fill_cnt #(
    parameter int               WIDTH    = 3,
    parameter logic [WIDTH-1:0] MAX_VAL  = '1,
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Clear has priority over counting; a saturating counter parks at MAX_VAL.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !(SATURATE && (cnt_q == MAX_VAL))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-fill controller: on a cache miss it issues one read per word of the
// block, counts the returning words into the data array and writes the tag
// with the last word. Completion depends only on counting valid returns.
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [2:0]        fill_word_offset,
    output logic              write_tag_array
);

    import cpu_cache_pkg::*;

    localparam int               BASE_W      = ADDR_W - BLOCK_OFFSET_W;
    localparam logic [3:0]       ISSUE_LIMIT = 4'(WORDS_PER_BLOCK);
    localparam logic [2:0]       LAST_WORD   = 3'(WORDS_PER_BLOCK - 1);

    fill_state_t       state_q;
    fill_state_t       state_d;
    logic [BASE_W-1:0] block_base_q;
    logic [BASE_W-1:0] block_base_d;

    logic       captureMiss;
    logic       issueEn;
    logic       recvEn;
    logic       lastWord;
    logic [3:0] issueCnt;
    logic [2:0] recvCnt;
    logic       unusedOffsetBits;

    // The byte offset of the missing access never matters: the whole block is fetched.
    assign unusedOffsetBits = ^miss_address[BLOCK_OFFSET_W-1:0];

    assign captureMiss = (state_q == IDLE) && miss_detected;
    assign issueEn     = (state_q == FILL) && (issueCnt < ISSUE_LIMIT);
    assign recvEn      = (state_q == FILL) && memory_data_valid;
    assign lastWord    = recvEn && (recvCnt == LAST_WORD);

    // Request counter: one step per issued read, parks at the block size.
    cache_fill_cnt #(
        .WIDTH    (4),
        .MAX_VAL  (ISSUE_LIMIT),
        .SATURATE (1'b1)
    ) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (captureMiss),
        .en_i  (issueEn),
        .cnt_o (issueCnt)
    );

    // Return counter: wraps back to zero after the last word of the block.
    cache_fill_cnt #(
        .WIDTH    (3),
        .MAX_VAL  (3'd7),
        .SATURATE (1'b0)
    ) u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (captureMiss),
        .en_i  (recvEn),
        .cnt_o (recvCnt)
    );

    // Next state and block capture; misses seen during a fill are ignored.
    always_comb begin
        state_d      = state_q;
        block_base_d = block_base_q;
        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    state_d      = FILL;
                    block_base_d = miss_address[ADDR_W-1:BLOCK_OFFSET_W];
                end
            end
            FILL: begin
                if (lastWord) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend only on registered state/counters and the return strobe.
    always_comb begin
        fsm_busy         = (state_q == FILL);
        mem_req          = issueEn;
        memory_address   = '0;
        write_data_array = recvEn;
        fill_word_offset = recvCnt;
        write_tag_array  = lastWord;
        if (issueEn) begin
            memory_address = {block_base_q, issueCnt[WORD_IDX_W-1:0], 1'b0};
        end
    end

    // State and block-base registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            block_base_q <= '0;
        end else begin
            state_q      <= state_d;
            block_base_q <= block_base_d;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a hand-derived vector table for the
// basic fill plus directed multi-cycle sequences checked against a small model.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_req;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  fill_word_offset;
    logic        write_tag_array;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state for the directed sequences.
    bit          mFill  = 1'b0;
    logic [11:0] mBase  = '0;
    int          mIssue = 0;
    int          mRecv  = 0;

    typedef struct {
        logic        rst;
        logic        miss;
        logic [15:0] addr;
        logic        valid;
        logic [22:0] expOut;
    } vec_t;

    vec_t basicVec[14];

    logic [22:0] actOut;
    assign actOut = {fsm_busy, mem_req, memory_address, write_data_array,
                     fill_word_offset, write_tag_array};

    // Free-running clock.
    always #5 clk = ~clk;

    cache_fill_fsm #(
        .WORDS_PER_BLOCK (8),
        .ADDR_W          (16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_req           (mem_req),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word_offset  (fill_word_offset),
        .write_tag_array   (write_tag_array)
    );

    task automatic applyStimulus(input logic r, input logic m,
                                 input logic [15:0] a, input logic v);
        @(negedge clk);
        rst_n             = r;
        miss_detected     = m;
        miss_address      = a;
        memory_data_valid = v;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [22:0] expected);
        testsRun++;
        if (actOut !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got busy,req,addr,wda,off,wta=%h required %h",
                     name, actOut, expected);
        end
    endtask

    task automatic checkValue(input string name, input logic [15:0] act,
                              input logic [15:0] expected);
        testsRun++;
        if (act !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h required %h", name, act, expected);
        end
    endtask

    task automatic stepModel(input string name, input logic r, input logic m,
                             input logic [15:0] a, input logic v);
        logic        eReq;
        logic [15:0] eAddr;
        logic        eWda;
        logic        eWta;
        applyStimulus(r, m, a, v);
        eReq  = mFill && (mIssue < 8);
        eAddr = eReq ? {mBase, 3'(mIssue), 1'b0} : 16'h0000;
        eWda  = mFill && v;
        eWta  = eWda && (mRecv == 7);
        checkOutput(name, {mFill, eReq, eAddr, eWda, 3'(mRecv), eWta});
        if (!r) begin
            mFill = 1'b0; mBase = '0; mIssue = 0; mRecv = 0;
        end else if (!mFill) begin
            if (m) begin
                mFill = 1'b1; mBase = a[15:4]; mIssue = 0; mRecv = 0;
            end
        end else begin
            if (eReq) mIssue++;
            if (v) begin
                if (mRecv == 7) begin
                    mFill = 1'b0;
                    mRecv = 0;
                end else begin
                    mRecv++;
                end
            end
        end
    endtask

    // Watchdog so the bench can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int tagCycle;
        int lastBusy;
        logic [31:0] gapMask;

        // Basic fill at 16'h1236 with 4-cycle latency, expectations by hand.
        for (int c = 0; c < 14; c++) begin
            logic        b, q, w, t;
            logic [15:0] ad;
            logic [2:0]  off;
            b   = (c >= 1) && (c <= 12);
            q   = (c >= 1) && (c <= 8);
            ad  = q ? 16'(16'h1230 + 2 * (c - 1)) : 16'h0000;
            w   = (c >= 5) && (c <= 12);
            off = w ? 3'(c - 5) : 3'd0;
            t   = (c == 12);
            basicVec[c].rst    = 1'b1;
            basicVec[c].miss   = (c == 0);
            basicVec[c].addr   = (c == 0) ? 16'h1236 : 16'h0000;
            basicVec[c].valid  = w;
            basicVec[c].expOut = {b, q, ad, w, off, t};
        end

        rst_n = 1'b0; miss_detected = 1'b0; miss_address = '0; memory_data_valid = 1'b0;
        repeat (2) @(posedge clk);
        stepModel("reset_state", 1'b0, 1'b0, 16'h0000, 1'b0);
        stepModel("reset_release", 1'b1, 1'b0, 16'h0000, 1'b0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(basicVec[i].rst, basicVec[i].miss, basicVec[i].addr, basicVec[i].valid);
            checkOutput($sformatf("basic_c%0d", i), basicVec[i].expOut);
        end
        mFill = 1'b0; mIssue = 0; mRecv = 0;

        // Miss held high through the fill with a new address from cycle 2.
        for (int c = 0; c <= 24; c++) begin
            stepModel($sformatf("busyMiss_c%0d", c), 1'b1, c <= 13,
                      (c < 2) ? 16'h1236 : 16'hABC0,
                      ((c >= 5) && (c <= 12)) || ((c >= 16) && (c <= 23)));
            if (c == 8)  checkValue("busyMiss_addr8", memory_address, 16'h123E);
            if (c == 13) checkValue("busyMiss_idle13", {15'd0, fsm_busy}, 16'h0000);
            if (c == 14) checkValue("busyMiss_addr14", memory_address, 16'hABC0);
        end

        // Gappy returns: valid in cycles 6,9,10,15,16,17,20,22.
        gapMask  = 32'h0053_8640;
        tagCycle = -1;
        lastBusy = -1;
        for (int c = 0; c <= 24; c++) begin
            stepModel($sformatf("gappy_c%0d", c), 1'b1, c == 0, 16'h1236, gapMask[c]);
            if (write_tag_array) tagCycle = c;
            if (fsm_busy)        lastBusy = c;
        end
        checkValue("gappy_tagCycle", 16'(tagCycle), 16'd22);
        checkValue("gappy_lastBusy", 16'(lastBusy), 16'd22);

        // Spurious returns while idle must not write anything.
        for (int c = 0; c < 4; c++) begin
            stepModel($sformatf("spurious_c%0d", c), 1'b1, 1'b0, 16'h0000, 1'b1);
            checkValue("spurious_wda", {14'd0, write_data_array, write_tag_array}, 16'h0000);
        end

        // Top-of-memory block; also shows the receive count started at 0.
        for (int c = 0; c <= 13; c++) begin
            stepModel($sformatf("boundary_c%0d", c), 1'b1, c == 0, 16'hFFFF,
                      (c >= 5) && (c <= 12));
            if (c == 1) checkValue("boundary_addr1", memory_address, 16'hFFF0);
            if (c == 8) checkValue("boundary_addr8", memory_address, 16'hFFFE);
            if (c == 5) checkValue("boundary_off5", {13'd0, fill_word_offset}, 16'h0000);
        end

        // Reset in cycle 7 of a fill, late returns, then a fresh miss.
        for (int c = 0; c <= 27; c++) begin
            stepModel($sformatf("rstMid_c%0d", c), c != 7, (c == 0) || (c == 13),
                      (c < 13) ? 16'h4568 : 16'h2222,
                      ((c >= 5) && (c <= 12)) || ((c >= 18) && (c <= 25)));
            if (c == 8)  checkOutput("rstMid_zero8", 23'd0);
            if (c == 14) checkValue("rstMid_addr14", memory_address, 16'h2220);
            if (c == 18) checkValue("rstMid_off18", {13'd0, fill_word_offset}, 16'h0000);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
